// File: rtl/wots_chain_gen.sv
// WOTS public-key generator: walks each secret seed through the F chain
// on the shared sha256 core and stores every chain end in the pk memory.
module wots_chain_gen #(
  parameter int SEED_NUM = 40,
  parameter int CHAIN_STEPS = 15,
  parameter int KEY_LEN = 256,
  parameter logic [255:0] XMSS_HASH_PADDING_F = 256'd0,
  localparam int AW = (SEED_NUM > 1) ? $clog2(SEED_NUM) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [255:0]       pub_seed,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      seed_mem_rd_addr,
  output logic               seed_mem_rd_en,
  input  logic [KEY_LEN-1:0] seed_rd_data,
  output logic               hash_start,
  output logic [1023:0]      hash_data_in,
  output logic               message_length,
  input  logic               hash_done,
  input  logic [KEY_LEN-1:0] hash_data_out,
  output logic [KEY_LEN-1:0] pk_wr_data,
  output logic [AW-1:0]      pk_mem_wr_addr,
  output logic               pk_mem_wr_en
);

  typedef enum logic [2:0] {
    IDLE, RD_SEED, LOAD, HSTART, HWAIT, WRITE, FIN
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0]      chain_idx;
  logic [7:0]         step_idx;
  logic [KEY_LEN-1:0] chain_val;
  logic               last_step;
  logic               last_chain;
  logic               run;
  logic [7:0]         cidx8;

  assign last_step  = ({1'b0, step_idx} + 9'd1) == 9'(CHAIN_STEPS);
  assign last_chain = chain_idx == AW'(SEED_NUM - 1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RD_SEED;
      RD_SEED: state_nx = LOAD;
      LOAD:    state_nx = (CHAIN_STEPS == 0) ? WRITE : HSTART;
      HSTART:  state_nx = HWAIT;
      HWAIT: begin
        if (hash_done) state_nx = last_step ? WRITE : HSTART;
      end
      WRITE:   state_nx = last_chain ? FIN : RD_SEED;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      chain_idx <= '0;
      step_idx  <= '0;
      chain_val <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) chain_idx <= '0;
        LOAD: begin
          chain_val <= seed_rd_data;
          step_idx  <= '0;
        end
        HWAIT: begin
          if (hash_done) begin
            chain_val <= hash_data_out;
            step_idx  <= step_idx + 8'd1;
          end
        end
        WRITE: if (!last_chain) chain_idx <= chain_idx + AW'(1);
        default: ;
      endcase
    end
  end

  // pub_seed is masked while idle so a reset leaves only the padding visible
  assign run   = state != IDLE;
  assign cidx8 = 8'(chain_idx);

  assign hash_data_in = {XMSS_HASH_PADDING_F,
                         run ? pub_seed : 256'd0,
                         240'b0, cidx8, step_idx, chain_val};

  assign busy = (reset & start & (state == IDLE))
              | ((state != IDLE) & (state != FIN));
  assign done             = state == FIN;
  assign seed_mem_rd_en   = state == RD_SEED;
  assign seed_mem_rd_addr = chain_idx;
  assign hash_start       = state == HSTART;
  assign message_length   = 1'b0;
  assign pk_mem_wr_en     = state == WRITE;
  assign pk_mem_wr_addr   = chain_idx;
  assign pk_wr_data       = chain_val;

endmodule

// File: tb/tb_wots_chain_gen.sv
// Directed bench for wots_chain_gen: small, zero-step and default-sized
// instances driven against a +1 hash model with a 3-cycle latency.
module tb_wots_chain_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [255:0] pub_seed = 256'hAB;

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- small instance: 4 chains, 2 steps
  logic          s_rst = 1'b0, s_start = 1'b0, s_inj = 1'b0;
  logic          s_busy, s_done, s_rd_en, s_hstart, s_ml, s_hd, s_wr_en;
  logic [1:0]    s_rd_addr, s_wr_addr;
  logic [255:0]  s_rd_data = '0, s_mdo = '0;
  logic [255:0]  s_hdo, s_wr_data;
  logic [1023:0] s_hdin;
  logic [2:0]    s_hcnt = '0;

  assign s_hd  = (s_hcnt == 3'd1) | s_inj;
  assign s_hdo = s_inj ? 256'hDEAD : s_mdo;

  wots_chain_gen #(.SEED_NUM(4), .CHAIN_STEPS(2)) u_s (
    .clk(clk), .reset(s_rst), .start(s_start), .pub_seed(pub_seed),
    .busy(s_busy), .done(s_done),
    .seed_mem_rd_addr(s_rd_addr), .seed_mem_rd_en(s_rd_en),
    .seed_rd_data(s_rd_data), .hash_start(s_hstart),
    .hash_data_in(s_hdin), .message_length(s_ml),
    .hash_done(s_hd), .hash_data_out(s_hdo),
    .pk_wr_data(s_wr_data), .pk_mem_wr_addr(s_wr_addr),
    .pk_mem_wr_en(s_wr_en)
  );

  always @(posedge clk) begin
    if (s_rd_en) s_rd_data <= 256'(s_rd_addr) + 256'd10;
    if (s_hstart) begin
      s_hcnt <= 3'd3;
      s_mdo  <= s_hdin[255:0] + 256'd1;
    end else if (s_hcnt != 3'd0) begin
      s_hcnt <= s_hcnt - 3'd1;
    end
  end

  int s_wn = 0, s_hs = 0, s_dn = 0, s_wcyc = 0, s_dcyc = 0;
  logic [1:0]    s_wa [256];
  logic [255:0]  s_wd [256];
  logic [1023:0] s_cap0 = '0, s_cap5 = '0;

  always @(negedge clk) begin
    if (s_wr_en) begin
      s_wa[s_wn % 256] = s_wr_addr;
      s_wd[s_wn % 256] = s_wr_data;
      s_wn++;
      s_wcyc = cyc;
    end
    if (s_hstart) begin
      if (s_hs == 0) s_cap0 = s_hdin;
      if (s_hs == 5) s_cap5 = s_hdin;
      s_hs++;
    end
    if (s_done) begin
      s_dn++;
      s_dcyc = cyc;
    end
  end

  // ---------------- zero-step instance: 4 chains, 0 steps
  logic          zd_rst = 1'b0, z_start = 1'b0;
  logic          z_busy, z_done, z_rd_en, z_hstart, z_ml, z_wr_en;
  logic          z_hd;
  logic [1:0]    z_rd_addr, z_wr_addr;
  logic [255:0]  z_rd_data = '0, z_hdo, z_wr_data;
  logic [1023:0] z_hdin;

  assign z_hd  = 1'b0;
  assign z_hdo = '0;

  wots_chain_gen #(.SEED_NUM(4), .CHAIN_STEPS(0)) u_z (
    .clk(clk), .reset(zd_rst), .start(z_start), .pub_seed(pub_seed),
    .busy(z_busy), .done(z_done),
    .seed_mem_rd_addr(z_rd_addr), .seed_mem_rd_en(z_rd_en),
    .seed_rd_data(z_rd_data), .hash_start(z_hstart),
    .hash_data_in(z_hdin), .message_length(z_ml),
    .hash_done(z_hd), .hash_data_out(z_hdo),
    .pk_wr_data(z_wr_data), .pk_mem_wr_addr(z_wr_addr),
    .pk_mem_wr_en(z_wr_en)
  );

  always @(posedge clk)
    if (z_rd_en) z_rd_data <= 256'(z_rd_addr) + 256'd10;

  int z_wn = 0, z_hs = 0, z_dn = 0, z_dcyc = 0;
  logic [1:0]   z_wa [8];
  logic [255:0] z_wd [8];

  always @(negedge clk) begin
    if (z_wr_en) begin
      z_wa[z_wn % 8] = z_wr_addr;
      z_wd[z_wn % 8] = z_wr_data;
      z_wn++;
    end
    if (z_hstart) z_hs++;
    if (z_done) begin
      z_dn++;
      z_dcyc = cyc;
    end
  end

  // ---------------- default instance: 40 chains, 15 steps
  logic          d_start = 1'b0, d_active = 1'b0;
  logic          d_busy, d_done, d_rd_en, d_hstart, d_ml, d_hd, d_wr_en;
  logic [5:0]    d_rd_addr, d_wr_addr;
  logic [255:0]  d_rd_data = '0, d_mdo = '0, d_wr_data;
  logic [1023:0] d_hdin;
  logic [2:0]    d_hcnt = '0;

  assign d_hd = d_hcnt == 3'd1;

  wots_chain_gen u_d (
    .clk(clk), .reset(zd_rst), .start(d_start), .pub_seed(pub_seed),
    .busy(d_busy), .done(d_done),
    .seed_mem_rd_addr(d_rd_addr), .seed_mem_rd_en(d_rd_en),
    .seed_rd_data(d_rd_data), .hash_start(d_hstart),
    .hash_data_in(d_hdin), .message_length(d_ml),
    .hash_done(d_hd), .hash_data_out(d_mdo),
    .pk_wr_data(d_wr_data), .pk_mem_wr_addr(d_wr_addr),
    .pk_mem_wr_en(d_wr_en)
  );

  always @(posedge clk) begin
    if (d_rd_en) d_rd_data <= 256'(d_rd_addr) + 256'd1000;
    if (d_hstart) begin
      d_hcnt <= 3'd3;
      d_mdo  <= d_hdin[255:0] + 256'd1;
    end else if (d_hcnt != 3'd0) begin
      d_hcnt <= d_hcnt - 3'd1;
    end
  end

  int d_wn = 0, d_hs = 0, d_dn = 0, d_dcyc = 0, d_gap = 0;
  logic [5:0]   d_wa [64];
  logic [255:0] d_wd [64];

  always @(negedge clk) begin
    if (d_wr_en) begin
      d_wa[d_wn % 64] = d_wr_addr;
      d_wd[d_wn % 64] = d_wr_data;
      d_wn++;
    end
    if (d_hstart) d_hs++;
    if (d_active && !d_busy && !d_done) d_gap++;
    if (d_done) begin
      d_dn++;
      d_dcyc = cyc;
    end
  end

  // ---------------- small-instance run with optional disturbances
  task automatic run_small(input string tag, input bit inj);
    int w0, h0, d0, st;
    bit ok;
    w0 = s_wn; h0 = s_hs; d0 = s_dn;
    @(posedge clk); #1;
    s_start = 1'b1;
    st = cyc;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      s_start = inj && (cyc - st == 10);
      s_inj   = inj && (s_rd_en || s_wr_en);
      if (s_dn != d0) begin
        ok = 1'b1;
        break;
      end
    end
    s_start = 1'b0;
    s_inj   = 1'b0;
    check({tag, " done_seen"}, 256'(ok), 256'd1);
    repeat (5) @(posedge clk);
    #1;
    check({tag, " writes"}, 256'(s_wn - w0), 256'd4);
    for (int k = 0; k < 4; k++) begin
      check({tag, " wr_addr"}, 256'(s_wa[(w0 + k) % 256]), 256'(k));
      check({tag, " wr_data"}, s_wd[(w0 + k) % 256], 256'(12 + k));
    end
    check({tag, " hash_starts"}, 256'(s_hs - h0), 256'd8);
    check({tag, " done_pulses"}, 256'(s_dn - d0), 256'd1);
    check({tag, " run_cycles"}, 256'(s_dcyc - st + 1), 256'd46);
    check({tag, " done_after_write"}, 256'(s_dcyc - s_wcyc), 256'd1);
    check({tag, " busy_idle"}, 256'(s_busy), 256'd0);
  endtask

  initial begin
    int w0, d0, h0, st;
    bit ok;

    // reset state, all instances held in reset
    #1;
    check("rst ctrl", 256'({s_busy, s_done, s_rd_en, s_hstart,
                            s_ml, s_wr_en}), 256'd0);
    check("rst rd_addr", 256'(s_rd_addr), 256'd0);
    check("rst wr_data", s_wr_data, 256'd0);
    check("rst hdin_seed", s_hdin[767:512], 256'd0);
    check("rst hdin_low", s_hdin[255:0], 256'd0);
    repeat (2) @(posedge clk);
    #1;
    s_rst  = 1'b1;
    zd_rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst busy", 256'(s_busy), 256'd0);
    check("post_rst hdin_seed", s_hdin[767:512], 256'd0);

    // scenarios 1 and 2
    run_small("basic", 1'b0);
    check("req0 pad", s_cap0[1023:768], 256'd0);
    check("req0 seed", s_cap0[767:512], 256'hAB);
    check("req0 idx", s_cap0[511:256], 256'h0000);
    check("req0 val", s_cap0[255:0], 256'd10);
    check("req5 pad", s_cap5[1023:768], 256'd0);
    check("req5 seed", s_cap5[767:512], 256'hAB);
    check("req5 idx", s_cap5[511:256], 256'h0201);
    check("req5 val", s_cap5[255:0], 256'd13);

    // scenario 4
    run_small("disturb", 1'b1);

    // scenario 5: reset during HWAIT of chain 1
    w0 = s_wn; d0 = s_dn;
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (s_hstart && s_wn == w0 + 1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("abort reach_chain1", 256'(ok), 256'd1);
    @(posedge clk); #2;
    s_rst = 1'b0;
    #1;
    check("abort ctrl", 256'({s_busy, s_done, s_rd_en, s_hstart,
                              s_ml, s_wr_en}), 256'd0);
    check("abort addrs", 256'({s_rd_addr, s_wr_addr}), 256'd0);
    check("abort wr_data", s_wr_data, 256'd0);
    check("abort hdin_hi", s_hdin[1023:512], 256'd0);
    check("abort hdin_lo", s_hdin[511:0], 256'd0);
    repeat (2) @(posedge clk);
    #1;
    s_rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort writes", 256'(s_wn - w0), 256'd1);
    check("abort no_done", 256'(s_dn - d0), 256'd0);
    check("abort busy", 256'(s_busy), 256'd0);
    run_small("rerun", 1'b0);

    // scenario 3: zero chain steps
    @(posedge clk); #1;
    z_start = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    z_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (z_dn != 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("zero done_seen", 256'(ok), 256'd1);
    repeat (3) @(posedge clk);
    #1;
    check("zero hash_starts", 256'(z_hs), 256'd0);
    check("zero writes", 256'(z_wn), 256'd4);
    for (int k = 0; k < 4; k++) begin
      check("zero wr_addr", 256'(z_wa[k]), 256'(k));
      check("zero wr_data", z_wd[k], 256'(10 + k));
    end
    check("zero run_cycles", 256'(z_dcyc - st + 1), 256'd14);
    check("zero done_pulses", 256'(z_dn), 256'd1);
    check("zero idle", 256'({z_busy, z_ml}), 256'd0);
    check("zero pad", z_hdin[1023:768], 256'd0);

    // scenario 6: default parameters
    @(posedge clk); #1;
    d_start  = 1'b1;
    d_active = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    d_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (d_dn != 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    d_active = 1'b0;
    check("dflt done_seen", 256'(ok), 256'd1);
    repeat (3) @(posedge clk);
    #1;
    check("dflt hash_starts", 256'(d_hs), 256'd600);
    check("dflt writes", 256'(d_wn), 256'd40);
    for (int k = 0; k < 40; k++) begin
      check("dflt wr_addr", 256'(d_wa[k]), 256'(k));
      check("dflt wr_data", d_wd[k], 256'(1015 + k));
    end
    check("dflt busy_gaps", 256'(d_gap), 256'd0);
    check("dflt run_cycles", 256'(d_dcyc - st + 1), 256'd2522);
    check("dflt done_pulses", 256'(d_dn), 256'd1);
    check("dflt idle", 256'({d_busy, d_ml}), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
